// File: rtl/ser_pkg.sv
// Shared types and helpers for the bit stream serializer.
package ser_pkg;

   typedef logic [0:0] state_t;

   localparam state_t ST_IDLE  = 1'b0;
   localparam state_t ST_SHIFT = 1'b1;

   // A one-bit counter is still needed for the narrowest legal word.
   function automatic int cnt_width(input int width);
      return (width > 2) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/ser_hold_reg.sv
// One-entry word register with a valid flag, used as a prefetch slot.
module ser_hold_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             take,
   output logic [WIDTH-1:0] data,
   output logic             full
);

   always_ff @(posedge clk) begin
      if (rst) begin
         data <= '0;
         full <= 1'b0;
      end else if (load) begin
         data <= load_data;
         full <= 1'b1;
      end else if (take) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/bit_stream_serializer.sv
// Parallel-in, serial-out bit streamer with valid/ready input handshake.
// Define SER_PREFETCH_EN to add a one-word holding register for gap-free streaming.
module bit_stream_serializer
   import ser_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             x_out,
   output logic             x_valid,
   output logic             word_done,
   output logic             busy
);

   localparam int            CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] shreg;
   logic             cur_bit;

   logic             accept;
   logic             last_bit;
   logic             load;
   logic [WIDTH-1:0] load_word;

   assign accept   = in_valid && in_ready;
   assign last_bit = (state == ST_SHIFT) && (cnt == '0);

`ifdef SER_PREFETCH_EN
   logic [WIDTH-1:0] hold_data;
   logic             hold_full;
   logic             hold_load;
   logic             hold_take;

   // The hold slot drains first at the last bit; otherwise a word arriving
   // on that exact edge bypasses the slot and goes straight to the shifter.
   assign in_ready  = (state == ST_IDLE) || !hold_full;
   assign hold_take = last_bit && hold_full;
   assign hold_load = accept && (state == ST_SHIFT) && !last_bit;
   assign load      = ((state == ST_IDLE) && accept) || (last_bit && (hold_full || accept));
   assign load_word = hold_take ? hold_data : in_data;

   ser_hold_reg #(
      .WIDTH(WIDTH)
   ) u_hold (
      .clk      (clk),
      .rst      (rst),
      .load     (hold_load),
      .load_data(in_data),
      .take     (hold_take),
      .data     (hold_data),
      .full     (hold_full)
   );
`else
   assign in_ready  = (state == ST_IDLE);
   assign load      = (state == ST_IDLE) && accept;
   assign load_word = in_data;
`endif

   // The first bit is emitted straight from the incoming word; the shifter
   // keeps the remaining bits aligned so the next one is always at its edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         shreg   <= '0;
         cur_bit <= IDLE_BIT;
      end else if (load) begin
         state   <= ST_SHIFT;
         cnt     <= CNT_LAST;
         cur_bit <= MSB_FIRST ? load_word[WIDTH-1] : load_word[0];
         shreg   <= MSB_FIRST ? (load_word << 1) : (load_word >> 1);
      end else if (last_bit) begin
         state   <= ST_IDLE;
         cur_bit <= IDLE_BIT;
      end else if (state == ST_SHIFT) begin
         cnt     <= cnt - 1'b1;
         cur_bit <= MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
         shreg   <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
      end
   end

   assign busy      = (state == ST_SHIFT);
   assign x_valid   = busy;
   assign x_out     = cur_bit;
   assign word_done = last_bit;

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Self-checking bench for bit_stream_serializer (WIDTH=8), MSB-first and LSB-first instances.
// Expectations adapt to SER_PREFETCH_EN when the bench is built with it.
module tb_bit_stream_serializer;

   localparam logic H = 1'b1;
   localparam logic L = 1'b0;
`ifdef SER_PREFETCH_EN
   localparam logic PF = 1'b1;
`else
   localparam logic PF = 1'b0;
`endif

   logic       clk = 1'b0;
   always #2 clk = ~clk;

   logic       rst, in_valid, in_ready, x_out, x_valid, word_done, busy;
   logic [7:0] in_data;
   logic       rst_b, in_valid_b, in_ready_b, x_out_b, x_valid_b, word_done_b, busy_b;
   logic [7:0] in_data_b;

   int nChecks = 0;
   int nFails  = 0;

   bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .x_out(x_out), .x_valid(x_valid), .word_done(word_done), .busy(busy)
   );

   bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
      .clk(clk), .rst(rst_b), .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .x_out(x_out_b), .x_valid(x_valid_b), .word_done(word_done_b), .busy(busy_b)
   );

   typedef struct {
      logic       r;
      logic       v;
      logic [7:0] d;
      logic       xo;
      logic       xv;
      logic       wd;
      logic       bz;
      logic       rdy;
   } vec_t;

   vec_t vecs[$];

   function automatic void addVec(input logic r, input logic v, input logic [7:0] d,
                                  input logic xo, input logic xv, input logic wd,
                                  input logic bz, input logic rdy);
      vec_t t;
      t.r = r; t.v = v; t.d = d;
      t.xo = xo; t.xv = xv; t.wd = wd; t.bz = bz; t.rdy = rdy;
      vecs.push_back(t);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are inspected 1 ns after the rising edge.
   task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d);
      @(negedge clk);
      rst      = r;
      in_valid = v;
      in_data  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input vec_t e);
      check($sformatf("%s x_out", tag),     x_out,     e.xo);
      check($sformatf("%s x_valid", tag),   x_valid,   e.xv);
      check($sformatf("%s word_done", tag), word_done, e.wd);
      check($sformatf("%s busy", tag),      busy,      e.bz);
      check($sformatf("%s in_ready", tag),  in_ready,  e.rdy);
   endtask

   // Two words offered back to back with in_valid held high.
   task automatic runPair();
      logic [15:0] bits;
      logic [7:0]  words [2];
      int          nbits, accepts, gaps;
      logic        hs;
      bits = '0; nbits = 0; accepts = 0; gaps = 0;
      words[0] = 8'hA5;
      words[1] = 8'h3C;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         rst = 1'b0;
         if (accepts < 2) begin
            in_valid = 1'b1;
            in_data  = words[accepts];
         end else begin
            in_valid = 1'b0;
         end
         hs = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (hs) accepts++;
         if (x_valid) begin
            bits = {bits[14:0], x_out};
            nbits++;
            check($sformatf("pair word_done bit%0d", nbits), word_done, (nbits == 8 || nbits == 16));
            if (accepts == 2 && nbits <= 8)
               check($sformatf("pair in_ready hold full bit%0d", nbits), in_ready, 1'b0);
         end else if (nbits > 0 && nbits < 16) begin
            gaps++;
         end
      end
      in_valid = 1'b0;
      check("pair bit stream", bits, 16'hA53C);
      check("pair bit count", nbits, 16);
      check("pair gap cycles", gaps, PF ? 0 : 1);
      check("pair accepts", accepts, 2);
   endtask

   // LSB-first instance; words offered while in_ready=0 must be dropped.
   task automatic runLsb();
      logic [15:0] lbits;
      int          nb;
      lbits = '0; nb = 0;
      @(negedge clk);
      rst_b = 1'b1; in_valid_b = 1'b0; in_data_b = 8'h00;
      @(posedge clk);
      #1;
      check("lsb reset x_valid", x_valid_b, 1'b0);
      check("lsb reset in_ready", in_ready_b, 1'b1);
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         rst_b = 1'b0;
         case (c)
            0:       begin in_valid_b = 1'b1; in_data_b = 8'h01; end
            1:       begin in_valid_b = 1'b1; in_data_b = 8'h80; check("lsb in_ready 2nd offer", in_ready_b, PF); end
            2:       begin in_valid_b = 1'b1; in_data_b = 8'hFF; check("lsb in_ready blocked", in_ready_b, 1'b0); end
            default: begin in_valid_b = 1'b0; in_data_b = 8'h00; end
         endcase
         @(posedge clk);
         #1;
         if (c == 0) check("lsb first bit latency", {x_valid_b, x_out_b}, 2'b11);
         if (x_valid_b) begin
            lbits = {lbits[14:0], x_out_b};
            nb++;
         end
      end
      in_valid_b = 1'b0;
      check("lsb bit stream", lbits, PF ? 16'h8001 : 16'h0080);
      check("lsb bit count", nb, PF ? 16 : 8);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
      rst_b = 1'b1; in_valid_b = 1'b0; in_data_b = 8'h00;

      // reset for two cycles
      addVec(H, L, 8'h00, L, L, L, L, H);
      addVec(H, L, 8'h00, L, L, L, L, H);
      // accept 8'b1011_0010, MSB first
      addVec(L, H, 8'hB2, H, H, L, H, PF);
      addVec(L, L, 8'h00, L, H, L, H, PF);
      addVec(L, L, 8'h00, H, H, L, H, PF);
      addVec(L, L, 8'h00, H, H, L, H, PF);
      addVec(L, L, 8'h00, L, H, L, H, PF);
      addVec(L, L, 8'h00, L, H, L, H, PF);
      addVec(L, L, 8'h00, H, H, L, H, PF);
      addVec(L, L, 8'h00, L, H, H, H, PF);
      addVec(L, L, 8'h00, L, L, L, L, H);
      // reset after three bits of 8'hF0
      addVec(L, H, 8'hF0, H, H, L, H, PF);
      addVec(L, L, 8'h00, H, H, L, H, PF);
      addVec(L, L, 8'h00, H, H, L, H, PF);
      addVec(H, L, 8'h00, L, L, L, L, H);
      // 8'hFF afterwards streams eight ones
      addVec(L, H, 8'hFF, H, H, L, H, PF);
      for (int i = 0; i < 6; i++) addVec(L, L, 8'h00, H, H, L, H, PF);
      addVec(L, L, 8'h00, H, H, H, H, PF);
      addVec(L, L, 8'h00, L, L, L, L, H);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].r, vecs[i].v, vecs[i].d);
         checkOutput($sformatf("vec%0d", i), vecs[i]);
      end

      runPair();
      runLsb();

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
